// File: rtl/jesd204b_pkg.sv
// jesd204b_pkg
// Shared JESD204B transmit-side definitions: 8b/10b control characters used
// on the link, the ILAS generator state encoding and the size of the link
// configuration block carried in the second ILAS multiframe.
// No ports (package).
package jesd204b_pkg;

    // Control characters (K-flag set when transmitted)
    localparam logic [7:0] K28_0 = 8'h1C;   // /R/ multiframe start
    localparam logic [7:0] K28_3 = 8'h7C;   // /A/ multiframe end
    localparam logic [7:0] K28_4 = 8'h9C;   // /Q/ config data start
    localparam logic [7:0] K28_5 = 8'hBC;   // /K/ code group sync

    // Number of link configuration octets carried in ILAS multiframe 1
    localparam int ILAS_CFG_OCTETS = 14;

    typedef enum logic [1:0] {
        ST_CGS       = 2'd0,
        ST_WAIT_LMFC = 2'd1,
        ST_ILAS      = 2'd2,
        ST_DATA      = 2'd3
    } ilas_gen_state_e;

    // Mod-256 sum of the configuration octets that precede FCHK
    function automatic logic [7:0] cfg_octet_sum(
        input logic [8*(ILAS_CFG_OCTETS-1)-1:0] octets
    );
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < ILAS_CFG_OCTETS - 1; i++) begin
            acc = acc + octets[8*i +: 8];
        end
        return acc;
    endfunction

endpackage

// File: rtl/ilas_generator_if.sv
// ilas_generator_if
// Transmit stream between the transport layer, the ILAS generator and the
// 8b/10b encoder.
//   tx_data_i   : user data word from the transport layer
//   tx_ready_o  : tx_data_i is consumed this cycle
//   data_o      : octets toward the encoder (octet n = data_o[8n+7:8n])
//   char_is_k_o : per-octet K-flag
//   ilas_done_o : link is in the user-data phase
// Modports: master = generator side, slave = transport/encoder side.
interface ilas_generator_if #(
    parameter int PARALLEL_OCTETS = 4
);
    logic [8*PARALLEL_OCTETS-1:0] tx_data_i;
    logic                         tx_ready_o;
    logic [8*PARALLEL_OCTETS-1:0] data_o;
    logic [PARALLEL_OCTETS-1:0]   char_is_k_o;
    logic                         ilas_done_o;

    modport master (
        input  tx_data_i,
        output tx_ready_o,
        output data_o,
        output char_is_k_o,
        output ilas_done_o
    );

    modport slave (
        output tx_data_i,
        input  tx_ready_o,
        input  data_o,
        input  char_is_k_o,
        input  ilas_done_o
    );
endinterface

// File: rtl/ilas_generator_fchk.sv
// ilas_fchk
// Combinational FCHK computation: mod-256 sum of configuration octets 0..12.
//   cfg_i  : in  104 - octets 0..12, octet n = cfg_i[8n+7:8n]
//   fchk_o : out 8   - checksum octet
module ilas_fchk
    import jesd204b_pkg::*;
(
    input  logic [8*(ILAS_CFG_OCTETS-1)-1:0] cfg_i,
    output logic [7:0]                       fchk_o
);

    // Checksum over the octets that precede FCHK
    always_comb begin
        fchk_o = cfg_octet_sum(cfg_i);
    end

endmodule

// File: rtl/ilas_generator.sv
// ilas_generator
// JESD204B transmit link-establishment sequencer. Sends /K/ (CGS) while
// SYNC~ is low, then after SYNC~ releases waits for an LMFC boundary and
// sends the ILAS multiframes, then forwards user data.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   sync_ni : SYNC~ (synchronous to clk_i), low requests CGS
//   lmfc_i  : single-cycle LMFC boundary pulse
//   cfg_i   : 14 link configuration octets, octet n = cfg_i[8n+7:8n]
//   bus     : ilas_generator_if.master (tx data in, octets/K-flags out)
// Build option: define ILAS_GEN_FCHK_EN to replace config octet 13 with the
// computed checksum of octets 0..12 at capture time.
module ilas_generator
    import jesd204b_pkg::*;
#(
    parameter int PARALLEL_OCTETS       = 4,
    parameter int OCTETS_PER_MULTIFRAME = 32,
    parameter int ILAS_MULTIFRAMES      = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         sync_ni,
    input  logic                         lmfc_i,
    input  logic [8*ILAS_CFG_OCTETS-1:0] cfg_i,
    ilas_generator_if.master             bus
);

    localparam int DATA_WIDTH = PARALLEL_OCTETS * 8;
    localparam int M_WORDS    = OCTETS_PER_MULTIFRAME / PARALLEL_OCTETS;
    localparam int WCNT_W     = (M_WORDS > 1) ? $clog2(M_WORDS) : 1;
    localparam int MCNT_W     = $clog2(ILAS_MULTIFRAMES + 1);
    localparam int CIDX_W     = $clog2(ILAS_CFG_OCTETS);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(M_WORDS - 1);
    localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(ILAS_MULTIFRAMES - 1);
    localparam logic [MCNT_W-1:0] MCNT_CFG  = MCNT_W'(1);

    ilas_gen_state_e             state_r, state_s;
    logic [WCNT_W-1:0]           wcnt_r, wcnt_s;
    logic [MCNT_W-1:0]           mcnt_r, mcnt_s;
    logic                        capture_s;
    logic [7:0]                  cfg_r     [ILAS_CFG_OCTETS];
    logic [7:0]                  cfg_cap_s [ILAS_CFG_OCTETS];
    logic [DATA_WIDTH-1:0]       data_r, data_s;
    logic [PARALLEL_OCTETS-1:0]  k_r, k_s;
    logic                        done_r;

`ifdef ILAS_GEN_FCHK_EN
    logic [7:0] fchk_s;

    ilas_fchk u_fchk (
        .cfg_i  (cfg_i[8*(ILAS_CFG_OCTETS-1)-1:0]),
        .fchk_o (fchk_s)
    );
`endif

    // Configuration image to capture at the LMFC that starts ILAS
    always_comb begin
        for (int i = 0; i < ILAS_CFG_OCTETS - 1; i++) begin
            cfg_cap_s[i] = cfg_i[8*i +: 8];
        end
`ifdef ILAS_GEN_FCHK_EN
        cfg_cap_s[ILAS_CFG_OCTETS-1] = fchk_s;
`else
        cfg_cap_s[ILAS_CFG_OCTETS-1] = cfg_i[8*(ILAS_CFG_OCTETS-1) +: 8];
`endif
    end

    // Next state and counters. Counters hold the position of the word that
    // will be on data_o after the next edge, so the output register can be
    // loaded directly from them. SYNC~ low overrides everything else.
    always_comb begin
        state_s   = state_r;
        wcnt_s    = wcnt_r;
        mcnt_s    = mcnt_r;
        capture_s = 1'b0;
        case (state_r)
            ST_CGS: begin
                if (sync_ni) begin
                    state_s = ST_WAIT_LMFC;
                end else begin
                    state_s = ST_CGS;
                end
            end
            ST_WAIT_LMFC: begin
                if (!sync_ni) begin
                    state_s = ST_CGS;
                end else if (lmfc_i) begin
                    state_s   = ST_ILAS;
                    wcnt_s    = {WCNT_W{1'b0}};
                    mcnt_s    = {MCNT_W{1'b0}};
                    capture_s = 1'b1;
                end else begin
                    state_s = ST_WAIT_LMFC;
                end
            end
            ST_ILAS: begin
                if (!sync_ni) begin
                    state_s = ST_CGS;
                end else begin
                    if (wcnt_r == WCNT_LAST) begin
                        wcnt_s = {WCNT_W{1'b0}};
                        mcnt_s = mcnt_r + MCNT_W'(1);
                    end else begin
                        wcnt_s = wcnt_r + WCNT_W'(1);
                        mcnt_s = mcnt_r;
                    end
                    // Enter DATA as the final ILAS word is loaded, so
                    // tx_ready_o rises while that word is on data_o.
                    if (wcnt_s == WCNT_LAST && mcnt_s == MCNT_LAST) begin
                        state_s = ST_DATA;
                    end else begin
                        state_s = ST_ILAS;
                    end
                end
            end
            ST_DATA: begin
                if (!sync_ni) begin
                    state_s = ST_CGS;
                end else begin
                    state_s = ST_DATA;
                end
            end
            default: begin
                state_s = ST_CGS;
            end
        endcase
    end

    // Output word for the next cycle: CGS, user data, or ILAS octets
    always_comb begin
        int               p;
        logic [CIDX_W-1:0] ci;
        p      = 0;
        ci     = {CIDX_W{1'b0}};
        data_s = {PARALLEL_OCTETS{K28_5}};
        k_s    = {PARALLEL_OCTETS{1'b1}};
        if (state_s == ST_CGS || state_s == ST_WAIT_LMFC) begin
            data_s = {PARALLEL_OCTETS{K28_5}};
            k_s    = {PARALLEL_OCTETS{1'b1}};
        end else if (state_r == ST_DATA) begin
            data_s = bus.tx_data_i;
            k_s    = {PARALLEL_OCTETS{1'b0}};
        end else begin
            // Entering or inside ILAS, including the final ILAS word
            for (int n = 0; n < PARALLEL_OCTETS; n++) begin
                p  = int'(wcnt_s) * PARALLEL_OCTETS + n;
                ci = CIDX_W'(p - 2);
                if (p == 0) begin
                    data_s[8*n +: 8] = K28_0;
                    k_s[n]           = 1'b1;
                end else if (p == OCTETS_PER_MULTIFRAME - 1) begin
                    data_s[8*n +: 8] = K28_3;
                    k_s[n]           = 1'b1;
                end else if (mcnt_s == MCNT_CFG && p == 1) begin
                    data_s[8*n +: 8] = K28_4;
                    k_s[n]           = 1'b1;
                end else if (mcnt_s == MCNT_CFG && p >= 2 && p <= ILAS_CFG_OCTETS + 1) begin
                    data_s[8*n +: 8] = cfg_r[ci];
                    k_s[n]           = 1'b0;
                end else begin
                    data_s[8*n +: 8] = 8'(p);
                    k_s[n]           = 1'b0;
                end
            end
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_CGS;
            wcnt_r  <= {WCNT_W{1'b0}};
            mcnt_r  <= {MCNT_W{1'b0}};
            data_r  <= {PARALLEL_OCTETS{K28_5}};
            k_r     <= {PARALLEL_OCTETS{1'b1}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            wcnt_r  <= wcnt_s;
            mcnt_r  <= mcnt_s;
            data_r  <= data_s;
            k_r     <= k_s;
            done_r  <= (state_s == ST_DATA);
        end
    end

    // Configuration snapshot, frozen for the whole ILAS
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ILAS_CFG_OCTETS; i++) begin
                cfg_r[i] <= 8'h00;
            end
        end else if (capture_s) begin
            cfg_r <= cfg_cap_s;
        end
    end

    assign bus.data_o      = data_r;
    assign bus.char_is_k_o = k_r;
    assign bus.ilas_done_o = done_r;
    assign bus.tx_ready_o  = (state_r == ST_DATA);

endmodule
